// File: rtl/fpga_hf_pkg.sv
// Shared opcodes, major-mode encodings and FSM type for the HF controller.
// The readback path is enabled by defining FPGA_CMD_READBACK_EN.
package fpga_hf_pkg;

  localparam logic [3:0] FPGA_CMD_SET_CONFREG = 4'b0001;

  localparam logic [2:0] HF_READ_TX       = 3'd0;
  localparam logic [2:0] HF_READ_RX_XCORR = 3'd1;
  localparam logic [2:0] HF_SIMULATE      = 3'd2;
  localparam logic [2:0] HF_ISO14443A     = 3'd3;
  localparam logic [2:0] HF_SNIFFER       = 3'd4;
  localparam logic [2:0] HF_OFF           = 3'd7;

  localparam logic [7:0] CONF_RESET = 8'hE0;

  typedef enum logic {
    ST_ACTIVE,
    ST_GUARD
  } hf_state_e;

endpackage

// File: rtl/hf_mode_ctrl_spi_cmd_rx.sv
// SPI frame receiver in the carrier domain: sync, edge detect, framing check.
// FPGA_CMD_READBACK_EN adds the miso readback shifter.
module spi_cmd_rx #(
  parameter int CMD_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             spck_i,
  input  logic             mosi_i,
  input  logic             ncs_i,
`ifdef FPGA_CMD_READBACK_EN
  input  logic [CMD_W-1:0] rb_data_i,
`endif
  output logic             miso_o,
  output logic             frame_valid_o,
  output logic             frame_err_o,
  output logic [CMD_W-1:0] frame_o
);

  localparam int CW = $clog2(CMD_W + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(CMD_W);
  localparam logic [CW-1:0] CNT_SAT  = CW'(CMD_W + 1);

  logic [2:0]       spck_q;
  logic [1:0]       mosi_q;
  logic [2:0]       ncs_q;
  logic [CMD_W-1:0] sh_q;
  logic [CW-1:0]    cnt_q;
  logic             valid_q;
  logic             err_q;

  logic spck_rise, ncs_fall, ncs_rise, ncs_low;

  // Index 1 is the synchronised value; index 2 is its previous cycle.
  assign spck_rise = spck_q[1] & ~spck_q[2];
  assign ncs_fall  = ~ncs_q[1] & ncs_q[2];
  assign ncs_rise  = ncs_q[1] & ~ncs_q[2];
  assign ncs_low   = ~ncs_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spck_q  <= '0;
      mosi_q  <= '0;
      ncs_q   <= '1;
      sh_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      spck_q  <= {spck_q[1:0], spck_i};
      mosi_q  <= {mosi_q[0], mosi_i};
      ncs_q   <= {ncs_q[1:0], ncs_i};
      valid_q <= ncs_rise && (cnt_q == CNT_FULL);
      err_q   <= ncs_rise && (cnt_q != CNT_FULL);
      if (spck_rise && ncs_low) begin
        sh_q <= {sh_q[CMD_W-2:0], mosi_q[1]};
        if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
      end
      if (ncs_fall) cnt_q <= '0;
    end
  end

  assign frame_valid_o = valid_q;
  assign frame_err_o   = err_q;
  assign frame_o       = sh_q;

`ifdef FPGA_CMD_READBACK_EN
  logic [CMD_W-1:0] rb_q;
  logic             spck_fall;

  assign spck_fall = ~spck_q[1] & spck_q[2];

  // Shift on the falling edge so the ARM sees a settled bit on its rise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rb_q <= '0;
    end else if (ncs_fall) begin
      rb_q <= rb_data_i;
    end else if (spck_fall && ncs_low) begin
      rb_q <= {rb_q[CMD_W-2:0], 1'b0};
    end
  end

  assign miso_o = ncs_low & rb_q[CMD_W-1];
`else
  assign miso_o = 1'b0;
`endif

endmodule

// File: rtl/hf_mode_ctrl.sv
// HF top: config word, guarded mode switch and per-mode output mux.
// FPGA_CMD_READBACK_EN enables status readback on miso.
module hf_mode_ctrl
  import fpga_hf_pkg::*;
#(
  parameter int CMD_W        = 16,
  parameter int OPC_W        = 4,
  parameter int NUM_MODES    = 8,
  parameter int SIG_W        = 11,
  parameter int GUARD_CYCLES = 16,
  parameter logic [SIG_W-1:0] SAFE_VALUE = {SIG_W{1'b0}}
) (
  input  logic                       ck_1356meg,
  input  logic                       nreset,
  input  logic                       spck,
  input  logic                       mosi,
  input  logic                       ncs,
  output logic                       miso,
  input  logic [NUM_MODES*SIG_W-1:0] mode_sigs,
  output logic [SIG_W-1:0]           out_sigs,
  output logic [7:0]                 conf_word,
  output logic [2:0]                 major_mode,
  output logic                       mode_switching,
  output logic                       cmd_valid,
  output logic [OPC_W-1:0]           cmd_opcode,
  output logic [CMD_W-OPC_W-1:0]     cmd_data
  ,output logic                      frame_err
);

  localparam int PAY_W = CMD_W - OPC_W;
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);

  logic             frame_valid;
  logic [CMD_W-1:0] frame;
  logic [OPC_W-1:0] opc;
  logic [PAY_W-1:0] payload;
  logic [7:0]       new_conf;
  logic             set_cfg;

  hf_state_e        state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [7:0]       conf_q, conf_d;
  logic [GW-1:0]    guard_q, guard_d;
  logic [SIG_W-1:0] out_q, out_d;
  logic             cmd_valid_q;
  logic [OPC_W-1:0] cmd_opc_q;
  logic [PAY_W-1:0] cmd_data_q;
  logic [SIG_W-1:0] bus [8];

  spi_cmd_rx #(
    .CMD_W(CMD_W)
  ) u_rx (
    .clk_i        (ck_1356meg),
    .rst_ni       (nreset),
    .spck_i       (spck),
    .mosi_i       (mosi),
    .ncs_i        (ncs),
`ifdef FPGA_CMD_READBACK_EN
    .rb_data_i    (CMD_W'({mode_switching, conf_q})),
`endif
    .miso_o       (miso),
    .frame_valid_o(frame_valid),
    .frame_err_o  (frame_err),
    .frame_o      (frame)
  );

  assign opc      = frame[CMD_W-1 -: OPC_W];
  assign payload  = frame[PAY_W-1:0];
  assign new_conf = payload[7:0];
  assign set_cfg  = frame_valid &&
                    (opc == OPC_W'(FPGA_CMD_SET_CONFREG));

  // Unpopulated mode slots read as the safe value.
  for (genvar g = 0; g < 8; g++) begin : g_bus
    if (g < NUM_MODES) begin : g_pop
      assign bus[g] = mode_sigs[g*SIG_W +: SIG_W];
    end else begin : g_safe
      assign bus[g] = SAFE_VALUE;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    conf_d  = conf_q;
    guard_d = guard_q;
    if (set_cfg) conf_d = new_conf;
    unique case (state_q)
      ST_ACTIVE: begin
        if (set_cfg && new_conf[7:5] != mode_q) begin
          state_d = ST_GUARD;
          guard_d = GUARD_LOAD;
        end
      end
      ST_GUARD: begin
        if (set_cfg && new_conf[7:5] != conf_q[7:5]) begin
          guard_d = GUARD_LOAD;
        end else if (guard_q == '0) begin
          state_d = ST_ACTIVE;
          mode_d  = conf_q[7:5];
        end else begin
          guard_d = guard_q - 1'b1;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
    out_d = (state_d == ST_GUARD) ? SAFE_VALUE : bus[mode_d];
  end

  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_ACTIVE;
      mode_q      <= CONF_RESET[7:5];
      conf_q      <= CONF_RESET;
      guard_q     <= '0;
      out_q       <= SAFE_VALUE;
      cmd_valid_q <= 1'b0;
      cmd_opc_q   <= '0;
      cmd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      conf_q      <= conf_d;
      guard_q     <= guard_d;
      out_q       <= out_d;
      cmd_valid_q <= frame_valid && !set_cfg;
      if (frame_valid && !set_cfg) begin
        cmd_opc_q  <= opc;
        cmd_data_q <= payload;
      end
    end
  end

  assign out_sigs       = out_q;
  assign conf_word      = conf_q;
  assign major_mode     = mode_q;
  assign mode_switching = (state_q == ST_GUARD);
  assign cmd_valid      = cmd_valid_q;
  assign cmd_opcode     = cmd_opc_q;
  assign cmd_data       = cmd_data_q;

endmodule

// File: tb/tb_hf_mode_ctrl.sv
// Directed plus randomized frames against a frame-level model of hf_mode_ctrl.
// Readback expectations follow FPGA_CMD_READBACK_EN.
module tb_hf_mode_ctrl;

  localparam int NM = 6;
  localparam int SW = 11;
  localparam int G  = 200;
  localparam int MW = NM * SW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          spck = 1'b0;
  logic          mosi = 1'b0;
  logic          ncs = 1'b1;
  logic          miso;
  logic [MW-1:0] msigs = '1;
  logic [SW-1:0] out_sigs;
  logic [7:0]    conf_word;
  logic [2:0]    major_mode;
  logic          mode_switching;
  logic          cmd_valid;
  logic [3:0]    cmd_opcode;
  logic [11:0]   cmd_data;
  logic          frame_err;

  hf_mode_ctrl #(
    .NUM_MODES(NM),
    .SIG_W(SW),
    .GUARD_CYCLES(G)
  ) dut (
    .ck_1356meg    (clk),
    .nreset        (rst_n),
    .spck          (spck),
    .mosi          (mosi),
    .ncs           (ncs),
    .miso          (miso),
    .mode_sigs     (msigs),
    .out_sigs      (out_sigs),
    .conf_word     (conf_word),
    .major_mode    (major_mode),
    .mode_switching(mode_switching),
    .cmd_valid     (cmd_valid),
    .cmd_opcode    (cmd_opcode),
    .cmd_data      (cmd_data),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  int n_valid = 0, n_err = 0, n_ms = 0, n_bad = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      n_valid += int'(cmd_valid);
      n_err   += int'(frame_err);
      n_ms    += int'(mode_switching);
      n_bad   += int'(mode_switching && out_sigs != '0);
    end
  end

  int n_pass = 0, n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  logic [7:0]  m_conf = 8'hE0;
  logic [2:0]  m_mode = 3'd7;
  logic [3:0]  m_opc = '0;
  logic [11:0] m_data = '0;
  longint      t_rise;

  function automatic logic [SW-1:0] ref_out(input int mode,
                                             input logic [MW-1:0] s);
    logic [MW-1:0] sh;
    if (mode >= NM) return '0;
    sh = s >> (mode * SW);
    return sh[SW-1:0];
  endfunction

  task automatic send(input logic [16:0] bits, input int n,
                      output logic [15:0] rb);
    rb = '0;
    ncs = 1'b1;
    spck = 1'b0;
    repeat (4) @(negedge clk);
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = bits[i];
      repeat (4) @(negedge clk);
      rb = {rb[14:0], miso};
      spck = 1'b1;
      repeat (4) @(negedge clk);
      spck = 1'b0;
    end
    repeat (4) @(negedge clk);
    ncs = 1'b1;
    t_rise = $time / 10;
  endtask

  task automatic do_frame(input logic [16:0] bits, input int n);
    int v0, e0, m0, b0, ev, ee, eg;
    logic [7:0] old, nc;
    logic [15:0] rb;
    v0 = n_valid; e0 = n_err; m0 = n_ms; b0 = n_bad;
    ev = 0; ee = 0; eg = 0;
    old = m_conf; nc = m_conf;
    if (n != 16) ee = 1;
    else if (bits[15:12] == 4'h1) begin
      nc = bits[7:0];
      if (bits[7:5] != m_mode) eg = G;
    end else begin
      ev = 1;
      m_opc = bits[15:12];
      m_data = bits[11:0];
    end
    send(bits, n, rb);
    repeat (2) @(negedge clk);
    chk("conf_early", conf_word, old);
    repeat (2) @(negedge clk);
    chk("conf_lat4", conf_word, nc);
    chk("ms_start", mode_switching, eg != 0);
    repeat (G + 10) @(negedge clk);
    m_conf = nc;
    m_mode = nc[7:5];
    chk("valid_cnt", n_valid - v0, ev);
    chk("err_cnt", n_err - e0, ee);
    chk("ms_cycles", n_ms - m0, eg);
    chk("guard_safe", n_bad - b0, 0);
    chk("conf", conf_word, m_conf);
    chk("major", major_mode, m_mode);
    chk("opcode", cmd_opcode, m_opc);
    chk("data", cmd_data, m_data);
    chk("out", out_sigs, ref_out(m_mode, msigs));
  endtask

  initial begin
    logic [15:0] rb, rb_exp;
    logic [16:0] bits;
    longint t1, t2;
    int m0, b0, v0, len;

    repeat (3) @(negedge clk);
    chk("rst_out", out_sigs, 0);
    chk("rst_major", major_mode, 7);
    chk("rst_conf", conf_word, 8'hE0);
    chk("rst_ms", mode_switching, 0);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_miso", miso, 0);
    chk("rst_opc", cmd_opcode, 0);
    chk("rst_data", cmd_data, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("off_out", out_sigs, ref_out(7, msigs));
    chk("off_major", major_mode, 7);
    chk("no_err", n_err, 0);

    msigs = MW'({$urandom, $urandom, $urandom});
    do_frame(17'h01020, 16);
    do_frame(17'h01023, 16);
    do_frame(17'h07FFF, 15);
    do_frame(17'h13020, 17);
    do_frame(17'h03ABC, 16);

    m0 = n_ms; b0 = n_bad; v0 = n_valid;
    send(17'h01000, 16, rb);
    t1 = t_rise;
    send(17'h01040, 16, rb);
    t2 = t_rise;
    send(17'h02000, 16, rb);
    repeat (G + 10) @(negedge clk);
`ifdef FPGA_CMD_READBACK_EN
    rb_exp = 16'h0140;
`else
    rb_exp = 16'h0000;
`endif
    m_conf = 8'h40; m_mode = 3'd2; m_opc = 4'h2; m_data = '0;
    chk("readback", rb, rb_exp);
    chk("restart_ms", n_ms - m0, (t2 - t1) + G);
    chk("restart_safe", n_bad - b0, 0);
    chk("restart_major", major_mode, 2);
    chk("restart_conf", conf_word, 8'h40);
    chk("restart_valid", n_valid - v0, 1);
    chk("restart_out", out_sigs, ref_out(2, msigs));

    for (int k = 0; k < 20; k++) begin
      msigs = MW'({$urandom, $urandom, $urandom});
      bits = 17'($urandom);
      len = 16;
      case ($urandom % 6)
        0: len = 15;
        1: len = 17;
        default: len = 16;
      endcase
      if (len == 16) begin
        if ($urandom % 2 == 1) bits[15:12] = 4'h1;
        else if (bits[15:12] == 4'h1) bits[15:12] = 4'h0;
      end
      do_frame(bits, len);
    end

    send(17'h010A5, 16, rb);
    repeat (20) @(negedge clk);
    chk("mid_guard", mode_switching, 1);
    #2 rst_n = 1'b0;
    #1;
    m_conf = 8'hE0; m_mode = 3'd7; m_opc = '0; m_data = '0;
    chk("rst2_conf", conf_word, m_conf);
    chk("rst2_ms", mode_switching, 0);
    chk("rst2_out", out_sigs, 0);
    chk("rst2_major", major_mode, m_mode);
    chk("rst2_opc", cmd_opcode, m_opc);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst2_off_out", out_sigs, ref_out(7, msigs));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
